// File: rtl/aes_block_tx_serializer_pkg.sv
// Shared definitions for the AES block-to-UART serializer: state encoding,
// block/byte widths and the counter-width helper.
package aes_block_tx_serializer_pkg;

    localparam int AES_BLOCK_BITS = 128;
    localparam int BYTE_W         = 8;
    localparam int DEFAULT_BAUD   = 115200;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    function automatic int cnt_w(input int maxv);
        return (maxv < 2) ? 1 : $clog2(maxv + 1);
    endfunction

endpackage

// File: rtl/aes_block_tx_serializer_byte_timer.sv
// Loadable down-counter with an expire flag; stops at zero.
module uart_byte_timer
    import aes_block_tx_serializer_pkg::*;
#(
    parameter int MAXV = 1,
    parameter int W    = cnt_w(MAXV)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (en && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/aes_block_tx_serializer.sv
// Takes one 8*NBYTES-bit block over valid/ready and streams it MSB byte first
// to a UART transmitter, pacing on tx_done with optional gap and timeout.
module aes_block_tx_serializer
    import aes_block_tx_serializer_pkg::*;
#(
    parameter int  NBYTES     = 16,
    parameter int  GAP_CYCLES = 0,
    parameter int  TIMEOUT    = 2000000,
    localparam int BLK_W      = BYTE_W * NBYTES,
    localparam int IDX_W      = (NBYTES < 2) ? 1 : $clog2(NBYTES)
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              blk_valid,
    input  logic [BLK_W-1:0]  blk_data,
    output logic              blk_ready,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_done,
    output logic              busy,
    output logic [IDX_W-1:0]  byte_idx,
    output logic              blk_done,
    output logic              timeout_err
);

    localparam int GAP_MAX = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    // Loaded in SEND; expiry is seen in the last WAIT cycle, so the error
    // pulse lands exactly TIMEOUT cycles after tx_start.
    localparam int TO_MAX  = (TIMEOUT > 1) ? TIMEOUT - 2 : 0;
    localparam int GAP_W   = cnt_w(GAP_MAX);
    localparam int TO_W    = cnt_w(TO_MAX);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_MAX);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TO_MAX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam bit GAP_EN = (GAP_CYCLES > 0);
    localparam bit TO_EN  = (TIMEOUT > 0);

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               blk_done_q, blk_done_d;
    logic               terr_q, terr_d;
    logic               gap_load, to_load, gap_exp, to_exp;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        blk_done_d = 1'b0;
        terr_d     = 1'b0;
        gap_load   = 1'b0;
        to_load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (blk_valid) begin
                    shreg_d = blk_data;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                to_load = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        blk_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        shreg_d = shreg_q << BYTE_W;
                        idx_d   = idx_q + 1'b1;
                        if (GAP_EN) begin
                            gap_load = 1'b1;
                            state_d  = ST_GAP;
                        end else begin
                            state_d  = ST_SEND;
                        end
                    end
                end else if (TO_EN && to_exp) begin
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_exp) state_d = ST_SEND;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            blk_done_q <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            blk_done_q <= blk_done_d;
            terr_q     <= terr_d;
        end
    end

    uart_byte_timer #(.MAXV(GAP_MAX)) u_gap_timer (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .load     (gap_load),
        .en       (state_q == ST_GAP),
        .load_val (GAP_LOAD),
        .expired  (gap_exp)
    );

    uart_byte_timer #(.MAXV(TO_MAX)) u_to_timer (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .load     (to_load),
        .en       (state_q == ST_WAIT),
        .load_val (TO_LOAD),
        .expired  (to_exp)
    );

    assign blk_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign tx_start    = (state_q == ST_SEND);
    assign tx_data     = shreg_q[BLK_W-1 -: BYTE_W];
    assign byte_idx    = idx_q;
    assign blk_done    = blk_done_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_aes_block_tx_serializer.sv
// Directed bench: dut0 runs GAP=0/TIMEOUT=50, dut1 runs GAP=5/no timeout.
// A UART model answers each tx_start with a one-cycle tx_done 10 cycles later.
module tb_aes_block_tx_serializer;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] BLK_B = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

    // dut0
    logic         v0 = 1'b0, spur0 = 1'b0, mdl0 = 1'b0;
    logic [127:0] d0 = '0;
    logic         rdy0, st0, busy0, bd0, te0, done_in0;
    logic [7:0]   txd0;
    logic [3:0]   idx0;
    assign done_in0 = mdl0 | spur0;

    aes_block_tx_serializer #(.NBYTES(16), .GAP_CYCLES(0), .TIMEOUT(50)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .blk_valid(v0), .blk_data(d0), .blk_ready(rdy0),
        .tx_data(txd0), .tx_start(st0), .tx_done(done_in0), .busy(busy0),
        .byte_idx(idx0), .blk_done(bd0), .timeout_err(te0));

    // dut1
    logic         v1 = 1'b0, mdl1 = 1'b0;
    logic [127:0] d1 = '0;
    logic         rdy1, st1, busy1, bd1, te1;
    logic [7:0]   txd1;
    logic [3:0]   idx1;

    aes_block_tx_serializer #(.NBYTES(16), .GAP_CYCLES(5), .TIMEOUT(0)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .blk_valid(v1), .blk_data(d1), .blk_ready(rdy1),
        .tx_data(txd1), .tx_start(st1), .tx_done(mdl1), .busy(busy1),
        .byte_idx(idx1), .blk_done(bd1), .timeout_err(te1));

    // UART model + logging for dut0; mute0 = start index from which no tx_done comes
    int cnt0 = 0, nst0 = 0, mute0 = 99, badrdy0 = 0;
    logic rdy_prev0 = 1'b0;
    logic [7:0] sb0[$];
    logic [3:0] si0[$];
    int sc0[$], dc0[$], tc0[$], ac0[$];

    initial forever begin
        @(negedge Clk);
        mdl0 = 1'b0;
        if (!Rst_n) cnt0 = 0;
        else if (cnt0 > 0) begin cnt0--; if (cnt0 == 0) mdl0 = 1'b1; end
        if (st0) begin
            sb0.push_back(txd0); si0.push_back(idx0); sc0.push_back(cyc);
            if (nst0 < mute0) cnt0 = 10;
            nst0++;
        end
        if (bd0) dc0.push_back(cyc);
        if (te0) tc0.push_back(cyc);
        // v0 now is what the previous edge sampled; rdy_prev0 is ready in that cycle
        if (v0 && rdy_prev0 && Rst_n) ac0.push_back(cyc - 1);
        if (busy0 && rdy0) badrdy0++;
        rdy_prev0 = rdy0;
    end

    int cnt1 = 0;
    int sc1[$], dc1[$];
    initial forever begin
        @(negedge Clk);
        mdl1 = 1'b0;
        if (!Rst_n) cnt1 = 0;
        else if (cnt1 > 0) begin cnt1--; if (cnt1 == 0) mdl1 = 1'b1; end
        if (st1) begin sc1.push_back(cyc); cnt1 = 10; end
        if (bd1) dc1.push_back(cyc);
    end

    task automatic tick();
        @(negedge Clk); #1;
    endtask

    task automatic clear0();
        sb0.delete(); si0.delete(); sc0.delete(); dc0.delete(); tc0.delete(); ac0.delete();
        nst0 = 0; mute0 = 99; badrdy0 = 0;
    endtask

    task automatic send0(input logic [127:0] data);
        v0 = 1'b1; d0 = data; tick(); v0 = 1'b0;
    endtask

    task automatic wait0(input int n, input int budget, output bit to);
        int k = 0;
        while (dc0.size() < n && tc0.size() == 0 && k < budget) begin tick(); k++; end
        to = (dc0.size() < n && tc0.size() == 0);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (rdy0 !== 1'b1)  begin errors++; $display("FAIL reset_ready got %b exp 1", rdy0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy0); end
        checks++; if (st0 !== 1'b0)   begin errors++; $display("FAIL reset_tx_start got %b exp 0", st0); end
        checks++; if (txd0 !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", txd0); end
        checks++; if (idx0 !== 4'd0)  begin errors++; $display("FAIL reset_byte_idx got %0d exp 0", idx0); end
        checks++; if (bd0 !== 1'b0 || te0 !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", bd0, te0); end
        checks++; if (rdy1 !== 1'b1)  begin errors++; $display("FAIL reset_ready1 got %b exp 1", rdy1); end
        Rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit to;
        clear0();
        send0(BLK_A);
        wait0(1, 400, to);
        repeat (3) tick();
        checks++; if (to) begin errors++; $display("FAIL basic_wait got done=%0d exp 1", dc0.size()); end
        checks++; if (sb0.size() != 16) begin errors++; $display("FAIL basic_count got %0d exp 16", sb0.size()); end
        for (int i = 0; i < sb0.size() && i < 16; i++) begin
            checks++;
            if (sb0[i] !== 8'(17 * i) || si0[i] !== 4'(i)) begin
                errors++; $display("FAIL basic_byte%0d got %h/%0d exp %h/%0d", i, sb0[i], si0[i], 8'(17 * i), i);
            end
            if (i > 0) begin
                checks++;
                if (sc0[i] - sc0[i-1] != 11) begin errors++; $display("FAIL basic_pace%0d got %0d exp 11", i, sc0[i] - sc0[i-1]); end
            end
        end
        if (ac0.size() == 1 && sc0.size() > 0) begin
            checks++; if (sc0[0] != ac0[0] + 1) begin errors++; $display("FAIL basic_first got %0d exp %0d", sc0[0], ac0[0] + 1); end
        end else begin
            checks++; errors++; $display("FAIL basic_accepts got %0d exp 1", ac0.size());
        end
        if (dc0.size() == 1 && sc0.size() == 16) begin
            checks++; if (dc0[0] != sc0[15] + 11) begin errors++; $display("FAIL basic_done_time got %0d exp %0d", dc0[0], sc0[15] + 11); end
        end else begin
            checks++; errors++; $display("FAIL basic_done_count got %0d exp 1", dc0.size());
        end
        checks++; if (badrdy0 != 0) begin errors++; $display("FAIL basic_ready_busy got %0d exp 0", badrdy0); end
        checks++; if (tc0.size() != 0) begin errors++; $display("FAIL basic_timeout got %0d exp 0", tc0.size()); end
    endtask

    task automatic test_gap();
        int k = 0;
        sc1.delete(); dc1.delete();
        v1 = 1'b1; d1 = BLK_A; tick(); v1 = 1'b0;
        while (dc1.size() < 1 && k < 600) begin tick(); k++; end
        checks++; if (sc1.size() != 16) begin errors++; $display("FAIL gap_count got %0d exp 16", sc1.size()); end
        // 10 cycles to tx_done, then 5 idle cycles, then the next start
        for (int i = 1; i < sc1.size() && i < 16; i++) begin
            checks++;
            if (sc1[i] - sc1[i-1] != 16) begin errors++; $display("FAIL gap_pace%0d got %0d exp 16", i, sc1[i] - sc1[i-1]); end
        end
        if (dc1.size() == 1 && sc1.size() == 16) begin
            checks++; if (dc1[0] != sc1[15] + 11) begin errors++; $display("FAIL gap_last got %0d exp %0d", dc1[0], sc1[15] + 11); end
        end else begin
            checks++; errors++; $display("FAIL gap_done got %0d exp 1", dc1.size());
        end
    endtask

    task automatic test_timeout();
        bit to;
        clear0();
        mute0 = 3;
        send0(BLK_A);
        wait0(1, 300, to);
        checks++; if (tc0.size() != 1) begin errors++; $display("FAIL to_pulse got %0d exp 1", tc0.size()); end
        checks++; if (rdy0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("FAIL to_idle got rdy=%b busy=%b exp 1/0", rdy0, busy0); end
        if (tc0.size() == 1 && sc0.size() == 4) begin
            checks++; if (tc0[0] != sc0[3] + 50) begin errors++; $display("FAIL to_time got %0d exp %0d", tc0[0], sc0[3] + 50); end
        end
        repeat (20) tick();
        checks++; if (sb0.size() != 4) begin errors++; $display("FAIL to_bytes got %0d exp 4", sb0.size()); end
        checks++; if (dc0.size() != 0) begin errors++; $display("FAIL to_no_done got %0d exp 0", dc0.size()); end
        checks++; if (tc0.size() != 1) begin errors++; $display("FAIL to_single got %0d exp 1", tc0.size()); end
    endtask

    task automatic test_spurious();
        bit to;
        clear0();
        tick();
        spur0 = 1'b1; tick(); spur0 = 1'b0; tick();
        checks++; if (idx0 !== 4'd3 || st0 !== 1'b0 || busy0 !== 1'b0) begin
            errors++; $display("FAIL spur_idle got idx=%0d st=%b busy=%b exp 3/0/0", idx0, st0, busy0); end
        v0 = 1'b1; d0 = BLK_B; tick(); v0 = 1'b0;
        checks++; if (st0 !== 1'b1) begin errors++; $display("FAIL spur_send_state got %b exp 1", st0); end
        spur0 = 1'b1; tick(); spur0 = 1'b0;
        checks++; if (idx0 !== 4'd0 || st0 !== 1'b0) begin
            errors++; $display("FAIL spur_send got idx=%0d st=%b exp 0/0", idx0, st0); end
        wait0(1, 400, to);
        repeat (3) tick();
        checks++; if (sb0.size() != 16 || dc0.size() != 1) begin
            errors++; $display("FAIL spur_count got %0d/%0d exp 16/1", sb0.size(), dc0.size()); end
        for (int i = 0; i < sb0.size() && i < 16; i++) begin
            checks++;
            if (sb0[i] !== 8'(15 * (i + 1)) || si0[i] !== 4'(i)) begin
                errors++; $display("FAIL spur_byte%0d got %h/%0d exp %h/%0d", i, sb0[i], si0[i], 8'(15 * (i + 1)), i);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int k = 0;
        clear0();
        send0(BLK_A);
        while (sb0.size() < 8 && k < 300) begin tick(); k++; end
        tick(); tick();
        checks++; if (idx0 !== 4'd7 || busy0 !== 1'b1 || st0 !== 1'b0) begin
            errors++; $display("FAIL rmid_wait got idx=%0d busy=%b st=%b exp 7/1/0", idx0, busy0, st0); end
        Rst_n = 1'b0;
        #1;
        checks++; if (busy0 !== 1'b0 || rdy0 !== 1'b1 || st0 !== 1'b0) begin
            errors++; $display("FAIL rmid_ctrl got busy=%b rdy=%b st=%b exp 0/1/0", busy0, rdy0, st0); end
        checks++; if (txd0 !== 8'h00 || idx0 !== 4'd0 || bd0 !== 1'b0 || te0 !== 1'b0) begin
            errors++; $display("FAIL rmid_data got %h/%0d/%b/%b exp 00/0/0/0", txd0, idx0, bd0, te0); end
        tick(); tick();
        Rst_n = 1'b1;
        repeat (60) tick();
        checks++; if (dc0.size() != 0 || tc0.size() != 0) begin
            errors++; $display("FAIL rmid_pulses got %0d/%0d exp 0/0", dc0.size(), tc0.size()); end
        clear0();
        send0(BLK_A);
        wait0(1, 400, to);
        checks++; if (sb0.size() != 16 || dc0.size() != 1) begin
            errors++; $display("FAIL rmid_resend got %0d/%0d exp 16/1", sb0.size(), dc0.size()); end
        if (sb0.size() == 16) begin
            checks++; if (sb0[0] !== 8'h00 || si0[0] !== 4'd0 || sb0[15] !== 8'hFF) begin
                errors++; $display("FAIL rmid_order got %h/%0d/%h exp 00/0/FF", sb0[0], si0[0], sb0[15]); end
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        clear0();
        tick();
        v0 = 1'b1; d0 = BLK_A;
        while (dc0.size() < 2 && k < 1000) begin
            tick(); k++;
            if (ac0.size() == 1 && busy0) d0 = BLK_B;
            if (ac0.size() >= 2 && busy0) v0 = 1'b0;
        end
        v0 = 1'b0;
        repeat (5) tick();
        checks++; if (sb0.size() != 32) begin errors++; $display("FAIL b2b_count got %0d exp 32", sb0.size()); end
        checks++; if (dc0.size() != 2 || ac0.size() != 2) begin
            errors++; $display("FAIL b2b_events got done=%0d acc=%0d exp 2/2", dc0.size(), ac0.size()); end
        for (int i = 0; i < sb0.size() && i < 32; i++) begin
            checks++;
            if (sb0[i] !== ((i < 16) ? 8'(17 * i) : 8'(15 * (i - 15)))) begin
                errors++; $display("FAIL b2b_byte%0d got %h exp %h", i, sb0[i], (i < 16) ? 8'(17 * i) : 8'(15 * (i - 15)));
            end
        end
        if (dc0.size() == 2 && ac0.size() == 2 && sc0.size() == 32) begin
            checks++; if (ac0[1] != dc0[0]) begin errors++; $display("FAIL b2b_accept got %0d exp %0d", ac0[1], dc0[0]); end
            checks++; if (sc0[16] != dc0[0] + 1) begin errors++; $display("FAIL b2b_start got %0d exp %0d", sc0[16], dc0[0] + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_timeout();
        test_spurious();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
